// File: rtl/mem_ram_pipe_if.sv
// Request/response bus for mem_ram_pipe: one request per cycle in, one registered response out.
interface mem_ram_pipe_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              ReqValid;
  logic              ReqReady;
  logic              rEn;
  logic              wEn;
  logic [31:0]       Adress;
  logic [NB-1:0]     ByteEn;
  logic [DATA_W-1:0] DataWrite;
  logic [DATA_W-1:0] DataRead;
  logic              RspValid;
  logic              Err;

  modport master (
    output ReqValid, rEn, wEn, Adress, ByteEn, DataWrite,
    input  ReqReady, DataRead, RspValid, Err
  );

  modport slave (
    input  ReqValid, rEn, wEn, Adress, ByteEn, DataWrite,
    output ReqReady, DataRead, RspValid, Err
  );
endinterface

// File: rtl/mem_ram_pipe.sv
// Single-port byte-enabled RAM with a zeroing sweep after reset and a 1-cycle registered response.
module mem_ram_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst,
  mem_ram_pipe_if.slave bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned HI    = LSB + IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              rsp_q, rsp_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              illegal;
  logic [IDX_W-1:0]  req_idx;

  assign req_idx = bus.Adress[LSB +: IDX_W];
  assign accept  = bus.ReqValid & rdy_q;

  // Bad opcode, sub-word offset, or address beyond the array.
  assign illegal = (bus.rEn == bus.wEn)
                 | ((bus.Adress & 32'(NB - 1)) != 32'd0)
                 | ((bus.Adress >> HI) != 32'd0);

  // Next-state, memory port and response decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = '0;
    mem_wdata = bus.DataWrite;

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_be    = '1;
        mem_wdata = '0;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          rsp_d = 1'b1;
          if (illegal) begin
            err_d = 1'b1;
          end else if (bus.wEn) begin
            mem_we = 1'b1;
            mem_be = bus.ByteEn;
          end else begin
            rdata_d = mem[req_idx];
          end
        end
      end
      default: state_d = INIT;
    endcase

    // Reset wins over everything, including a request racing the reset edge.
    if (rst) begin
      state_d = INIT;
      cnt_d   = '0;
      rsp_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      mem_we  = 1'b0;
    end

    rdy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      rsp_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ReqReady = rdy_q;
  assign bus.RspValid = rsp_q;
  assign bus.Err      = err_q;
  assign bus.DataRead = rdata_q;

endmodule

// File: tb/tb_mem_ram_pipe.sv
// Directed bench for mem_ram_pipe: default 32x256 instance plus a 16x4 instance.
module tb_mem_ram_pipe;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rdy0_at;
  int   rdy1_at;
  int   pulses;

  always #5 clk = ~clk;

  mem_ram_pipe_if #(.DATA_W(32)) if0 ();
  mem_ram_pipe_if #(.DATA_W(16)) if1 ();

  mem_ram_pipe #(.DATA_W(32), .DEPTH(256)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mem_ram_pipe #(.DATA_W(16), .DEPTH(4))   dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on the 32-bit bus, advance one edge, leave it asserted.
  task automatic issue0(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    if0.ReqValid  = 1'b1;
    if0.rEn       = rd;
    if0.wEn       = wr;
    if0.Adress    = addr;
    if0.ByteEn    = be;
    if0.DataWrite = wd;
    @(posedge clk); #1;
  endtask

  task automatic issue1(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] be, input logic [15:0] wd);
    if1.ReqValid  = 1'b1;
    if1.rEn       = rd;
    if1.wEn       = wr;
    if1.Adress    = addr;
    if1.ByteEn    = be;
    if1.DataWrite = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if0.ReqValid = 1'b0;
    if1.ReqValid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    if0.ReqValid = 1'b0; if0.rEn = 1'b0; if0.wEn = 1'b0;
    if0.Adress = '0; if0.ByteEn = '0; if0.DataWrite = '0;
    if1.ReqValid = 1'b0; if1.rEn = 1'b0; if1.wEn = 1'b0;
    if1.Adress = '0; if1.ByteEn = '0; if1.DataWrite = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",    32'(if0.ReqReady), 32'd0);
    chk("rst_rspvalid", 32'(if0.RspValid), 32'd0);
    chk("rst_dataread", if0.DataRead,      32'd0);
    chk("rst_err",      32'(if0.Err),      32'd0);

    // Release reset and measure how long each sweep takes.
    rst = 1'b0;
    rdy0_at = 0;
    rdy1_at = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (rdy1_at == 0 && if1.ReqReady) rdy1_at = n;
      if (if0.ReqReady) begin
        rdy0_at = n;
        break;
      end
    end
    chk("init_cycles_256", 32'(rdy0_at), 32'd256);
    chk("init_cycles_4",   32'(rdy1_at), 32'd4);

    issue0(1'b1, 1'b0, 32'h3FC, 4'h0, 32'h0);
    chk("init_rd_valid", 32'(if0.RspValid), 32'd1);
    chk("init_rd_data",  if0.DataRead,      32'h0);
    chk("init_rd_err",   32'(if0.Err),      32'd0);
    idle();
    chk("idle_rspvalid", 32'(if0.RspValid), 32'd0);
    chk("idle_dataread", if0.DataRead,      32'd0);

    // Byte-enable merge.
    issue0(1'b0, 1'b1, 32'h10, 4'b1111, 32'h11223344);
    chk("wr_full_data", if0.DataRead, 32'd0);
    issue0(1'b0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
    issue0(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
    chk("be_merge", if0.DataRead, 32'h11BB33DD);
    idle();

    // Read immediately after write to the same word.
    issue0(1'b0, 1'b1, 32'h20, 4'b1111, 32'hDEADBEEF);
    chk("b2b_wr_valid", 32'(if0.RspValid), 32'd1);
    chk("b2b_wr_err",   32'(if0.Err),      32'd0);
    issue0(1'b1, 1'b0, 32'h20, 4'b0000, 32'h0);
    chk("b2b_rd_valid", 32'(if0.RspValid), 32'd1);
    chk("b2b_rd_data",  if0.DataRead,      32'hDEADBEEF);
    idle();

    // Illegal requests leave memory alone.
    issue0(1'b0, 1'b1, 32'h40, 4'b1111, 32'hCAFEF00D);
    issue0(1'b1, 1'b1, 32'h40, 4'b1111, 32'h12345678);
    chk("both_en_err",  32'(if0.Err), 32'd1);
    chk("both_en_data", if0.DataRead, 32'd0);
    issue0(1'b1, 1'b0, 32'h41, 4'b0000, 32'h0);
    chk("misalign_err",  32'(if0.Err), 32'd1);
    chk("misalign_data", if0.DataRead, 32'd0);
    issue0(1'b1, 1'b0, 32'h400, 4'b0000, 32'h0);
    chk("range_err",  32'(if0.Err),      32'd1);
    chk("range_vld",  32'(if0.RspValid), 32'd1);
    issue0(1'b0, 1'b0, 32'h40, 4'b1111, 32'h0BADBAD0);
    chk("no_en_err", 32'(if0.Err), 32'd1);
    issue0(1'b0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF);
    chk("be0_err", 32'(if0.Err), 32'd0);
    issue0(1'b1, 1'b0, 32'h40, 4'b0000, 32'h0);
    chk("after_illegal_data", if0.DataRead, 32'hCAFEF00D);
    chk("after_illegal_err",  32'(if0.Err), 32'd0);
    idle();

    // Mid-operation reset, then a request while not ready.
    issue0(1'b0, 1'b1, 32'h8, 4'b1111, 32'h5);
    chk("pre_rst_valid", 32'(if0.RspValid), 32'd1);
    if0.ReqValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_valid", 32'(if0.RspValid), 32'd0);
    chk("rst_ready_low",  32'(if0.ReqReady), 32'd0);
    rst = 1'b0;
    if0.ReqValid = 1'b1;
    if0.rEn = 1'b1; if0.wEn = 1'b0; if0.Adress = 32'h8;
    pulses = 0;
    rdy0_at = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (if0.RspValid) pulses++;
      if (if0.ReqReady) begin
        rdy0_at = n;
        if0.ReqValid = 1'b0;
        break;
      end
    end
    chk("notready_pulses", 32'(pulses),  32'd0);
    chk("reinit_cycles",   32'(rdy0_at), 32'd256);
    issue0(1'b1, 1'b0, 32'h8, 4'b0000, 32'h0);
    chk("reinit_rd_data",  if0.DataRead,      32'h0);
    chk("reinit_rd_valid", 32'(if0.RspValid), 32'd1);
    idle();

    // Narrow/shallow instance.
    issue1(1'b1, 1'b0, 32'h8, 2'b00, 16'h0);
    chk("p_range_err", 32'(if1.Err), 32'd1);
    issue1(1'b0, 1'b1, 32'h6, 2'b10, 16'hABCD);
    chk("p_wr_err", 32'(if1.Err), 32'd0);
    issue1(1'b1, 1'b0, 32'h6, 2'b00, 16'h0);
    chk("p_rd_data", 32'(if1.DataRead), 32'h0000AB00);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
